// File: rtl/gpr_wb_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : gpr_wb_arbiter_if
// Purpose  : Bundles the three writeback handshakes (LSU, ALU, MDU), the issue
//            and flush inputs, the register file write port and the busy
//            scoreboard of gpr_wb_arbiter.
// Ports    : *_wb_valid/addr/data  source -> arbiter writeback request
//            *_wb_ready            arbiter -> source, accepted this cycle
//            iss_en/iss_addr       issue of a GPR-writing instruction
//            flush                 clear the scoreboard
//            wr_en/wr_addr/wr_data registered register file write port
//            busy                  per-GPR pending-write scoreboard
// Modports : master = sources / issue side, slave = arbiter
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`ifndef OPERAND_WIDTH
`define OPERAND_WIDTH 32
`endif

interface gpr_wb_arbiter_if #(
   parameter int WIDTH = `OPERAND_WIDTH
);
   logic             alu_wb_valid;
   logic [4:0]       alu_wb_addr;
   logic [WIDTH-1:0] alu_wb_data;
   logic             alu_wb_ready;
   logic             lsu_wb_valid;
   logic [4:0]       lsu_wb_addr;
   logic [WIDTH-1:0] lsu_wb_data;
   logic             lsu_wb_ready;
   logic             mdu_wb_valid;
   logic [4:0]       mdu_wb_addr;
   logic [WIDTH-1:0] mdu_wb_data;
   logic             mdu_wb_ready;
   logic             iss_en;
   logic [4:0]       iss_addr;
   logic             flush;
   logic             wr_en;
   logic [4:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [31:0]      busy;

   modport master (
      output alu_wb_valid, alu_wb_addr, alu_wb_data,
      output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
      output mdu_wb_valid, mdu_wb_addr, mdu_wb_data,
      output iss_en, iss_addr, flush,
      input  alu_wb_ready, lsu_wb_ready, mdu_wb_ready,
      input  wr_en, wr_addr, wr_data, busy
   );

   modport slave (
      input  alu_wb_valid, alu_wb_addr, alu_wb_data,
      input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
      input  mdu_wb_valid, mdu_wb_addr, mdu_wb_data,
      input  iss_en, iss_addr, flush,
      output alu_wb_ready, lsu_wb_ready, mdu_wb_ready,
      output wr_en, wr_addr, wr_data, busy
   );
endinterface

`default_nettype wire

// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : gpr_wb_arbiter
// Purpose  : Arbitrates the single GPR write port between LSU, ALU and MDU
//            writeback sources (fixed order LSU > ALU > MDU, with starvation
//            promotion), registers the winning write, and maintains a busy
//            scoreboard of GPRs with outstanding writes.
// Ports    : clk  clock, rising edge
//            rst  asynchronous active-high reset
//            wb   gpr_wb_arbiter_if.slave (handshakes, issue, flush,
//                 write port, busy)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`ifndef OPERAND_WIDTH
`define OPERAND_WIDTH 32
`endif

module gpr_wb_arbiter #(
   parameter int WIDTH      = `OPERAND_WIDTH,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   gpr_wb_arbiter_if.slave     wb
);

   // Source slots, listed in fixed priority order (lowest index wins).
   localparam int         N_SRC      = 3;
   localparam int         SRC_LSU    = 0;
   localparam int         SRC_ALU    = 1;
   localparam int         SRC_MDU    = 2;
   localparam logic [2:0] C_STARVE   = 3'(STARVE_MAX);

   logic [N_SRC-1:0] src_valid;
   logic [4:0]       src_addr [N_SRC];
   logic [WIDTH-1:0] src_data [N_SRC];

   logic [N_SRC-1:0] starving;
   logic [N_SRC-1:0] cand;
   logic [N_SRC-1:0] grant;
   logic [4:0]       sel_addr;
   logic [WIDTH-1:0] sel_data;
   logic [31:0]      clr_mask;
   logic [31:0]      set_mask;

   logic [2:0]       cnt_q [N_SRC];
   logic [2:0]       cnt_d [N_SRC];
   logic             wr_en_q,   wr_en_d;
   logic [4:0]       wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0] wr_data_q, wr_data_d;
   logic [31:0]      busy_q,    busy_d;

   assign src_valid[SRC_LSU] = wb.lsu_wb_valid;
   assign src_valid[SRC_ALU] = wb.alu_wb_valid;
   assign src_valid[SRC_MDU] = wb.mdu_wb_valid;
   assign src_addr[SRC_LSU]  = wb.lsu_wb_addr;
   assign src_addr[SRC_ALU]  = wb.alu_wb_addr;
   assign src_addr[SRC_MDU]  = wb.mdu_wb_addr;
   assign src_data[SRC_LSU]  = wb.lsu_wb_data;
   assign src_data[SRC_ALU]  = wb.alu_wb_data;
   assign src_data[SRC_MDU]  = wb.mdu_wb_data;

   always_comb begin
      starving  = '0;
      sel_addr  = '0;
      sel_data  = '0;
      clr_mask  = '0;
      set_mask  = '0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      for (int i = 0; i < N_SRC; i++) begin
         starving[i] = src_valid[i] && (cnt_q[i] == C_STARVE);
      end

      // Starving sources form an exclusive group; the isolate-lowest-set-bit
      // trick then picks the first candidate in priority order. Readies are
      // forced low while reset is held so the sources see no acceptance.
      cand  = (|starving) ? starving : src_valid;
      grant = (cand & (~cand + 3'd1)) & {N_SRC{~rst}};

      for (int i = 0; i < N_SRC; i++) begin
         if (grant[i]) begin
            sel_addr = src_addr[i];
            sel_data = src_data[i];
         end
         if (grant[i] || !src_valid[i]) begin
            cnt_d[i] = 3'd0;
         end else if (cnt_q[i] == C_STARVE) begin
            cnt_d[i] = cnt_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 3'd1;
         end
      end

      // A grant to x0 completes the handshake but never writes the regfile.
      if ((|grant) && (sel_addr != 5'd0)) begin
         wr_en_d   = 1'b1;
         wr_addr_d = sel_addr;
         wr_data_d = sel_data;
      end

      if (|grant)    clr_mask = 32'd1 << sel_addr;
      if (wb.iss_en) set_mask = 32'd1 << wb.iss_addr;

      // Set is applied after clear: the issued instruction is newer than the
      // completing write to the same register.
      if (wb.flush) busy_d = '0;
      else          busy_d = (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= '0;
         for (int i = 0; i < N_SRC; i++) cnt_q[i] <= 3'd0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         for (int i = 0; i < N_SRC; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign wb.lsu_wb_ready = grant[SRC_LSU];
   assign wb.alu_wb_ready = grant[SRC_ALU];
   assign wb.mdu_wb_ready = grant[SRC_MDU];
   assign wb.wr_en        = wr_en_q;
   assign wb.wr_addr      = wr_addr_q;
   assign wb.wr_data      = wr_data_q;
   assign wb.busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_gpr_wb_arbiter
// Purpose  : Self-checking bench for gpr_wb_arbiter: directed vector table,
//            hand-written reset/starvation sequences and randomized traffic
//            compared against a behavioural reference model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_gpr_wb_arbiter;

   localparam int WIDTH      = 32;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gpr_wb_arbiter_if #(.WIDTH(WIDTH)) bus ();

   gpr_wb_arbiter #(.WIDTH(WIDTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Current stimulus; slot 0 = LSU, 1 = ALU, 2 = MDU.
   logic        cur_v [3];
   logic [4:0]  cur_a [3];
   logic [31:0] cur_d [3];
   logic        cur_ie, cur_fl;
   logic [4:0]  cur_ia;

   // Reference model state.
   int          m_cnt [3];
   logic        m_wr_en;
   logic [4:0]  m_wr_addr;
   logic [31:0] m_wr_data;
   logic [31:0] m_busy;

   typedef struct {
      logic [2:0]  v;
      logic [4:0]  la, aa, ma;
      logic [31:0] ld, ad, md;
      logic        ie;
      logic [4:0]  ia;
      logic        fl;
      logic [2:0]  er;
      logic        ew;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic [31:0] eb;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] v,
                               input logic [4:0] la, input logic [31:0] ld,
                               input logic [4:0] aa, input logic [31:0] ad,
                               input logic [4:0] ma, input logic [31:0] md,
                               input logic ie, input logic [4:0] ia, input logic fl,
                               input logic [2:0] er, input logic ew,
                               input logic [4:0] ea, input logic [31:0] ed,
                               input logic [31:0] eb);
      vec_t r;
      r.v = v; r.la = la; r.ld = ld; r.aa = aa; r.ad = ad; r.ma = ma; r.md = md;
      r.ie = ie; r.ia = ia; r.fl = fl; r.er = er; r.ew = ew; r.ea = ea; r.ed = ed; r.eb = eb;
      return r;
   endfunction

   task automatic clear_inputs();
      for (int p = 0; p < 3; p++) begin
         cur_v[p] = 1'b0; cur_a[p] = '0; cur_d[p] = '0;
      end
      cur_ie = 1'b0; cur_ia = '0; cur_fl = 1'b0;
   endtask

   task automatic drive();
      bus.lsu_wb_valid = cur_v[0]; bus.lsu_wb_addr = cur_a[0]; bus.lsu_wb_data = cur_d[0];
      bus.alu_wb_valid = cur_v[1]; bus.alu_wb_addr = cur_a[1]; bus.alu_wb_data = cur_d[1];
      bus.mdu_wb_valid = cur_v[2]; bus.mdu_wb_addr = cur_a[2]; bus.mdu_wb_data = cur_d[2];
      bus.iss_en = cur_ie; bus.iss_addr = cur_ia; bus.flush = cur_fl;
   endtask

   task automatic model_reset();
      for (int p = 0; p < 3; p++) m_cnt[p] = 0;
      m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_busy = '0;
   endtask

   // Winner: first starving requester in priority order, else first requester.
   function automatic int model_pick();
      for (int p = 0; p < 3; p++)
         if (cur_v[p] && m_cnt[p] == STARVE_MAX) return p;
      for (int p = 0; p < 3; p++)
         if (cur_v[p]) return p;
      return -1;
   endfunction

   function automatic logic [2:0] dut_rdy();
      return {bus.mdu_wb_ready, bus.alu_wb_ready, bus.lsu_wb_ready};
   endfunction

   // One clock: called at posedge+1, returns at the next posedge+1.
   task automatic step(output logic [2:0] rdy);
      int         g;
      logic [2:0] exp_r;
      drive();
      #4;
      rdy   = dut_rdy();
      g     = model_pick();
      exp_r = '0;
      if (g >= 0) exp_r[g] = 1'b1;
      chk("model_ready", {29'd0, rdy}, {29'd0, exp_r});
      for (int p = 0; p < 3; p++) begin
         if (p == g || !cur_v[p]) m_cnt[p] = 0;
         else if (m_cnt[p] < STARVE_MAX) m_cnt[p] = m_cnt[p] + 1;
      end
      if (g >= 0 && cur_a[g] != 5'd0) begin
         m_wr_en = 1'b1; m_wr_addr = cur_a[g]; m_wr_data = cur_d[g];
      end else begin
         m_wr_en = 1'b0;
      end
      if (cur_fl) m_busy = '0;
      else begin
         if (g >= 0) m_busy[cur_a[g]] = 1'b0;
         if (cur_ie) m_busy[cur_ia] = 1'b1;
         m_busy[0] = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("model_wr_en", {31'd0, bus.wr_en}, {31'd0, m_wr_en});
      if (m_wr_en) begin
         chk("model_wr_addr", {27'd0, bus.wr_addr}, {27'd0, m_wr_addr});
         chk("model_wr_data", bus.wr_data, m_wr_data);
      end
      chk("model_busy", bus.busy, m_busy);
   endtask

   vec_t       tbl [22];
   logic [2:0] r;

   initial begin
      // Directed table: single write, priority, scoreboard, x0, flush.
      tbl[0]  = mk(3'b010, 0,0, 5,32'hDEADBEEF, 0,0, 0,0,0, 3'b010, 1,5,32'hDEADBEEF, 32'h0);
      tbl[1]  = mk(3'b000, 0,0, 0,0, 0,0, 0,0,0, 3'b000, 0,0,0, 32'h0);
      tbl[2]  = mk(3'b111, 1,32'h11, 2,32'h22, 3,32'h33, 0,0,0, 3'b001, 1,1,32'h11, 32'h0);
      tbl[3]  = mk(3'b110, 0,0, 2,32'h22, 3,32'h33, 0,0,0, 3'b010, 1,2,32'h22, 32'h0);
      tbl[4]  = mk(3'b100, 0,0, 0,0, 3,32'h33, 0,0,0, 3'b100, 1,3,32'h33, 32'h0);
      tbl[5]  = mk(3'b000, 0,0, 0,0, 0,0, 1,7,0, 3'b000, 0,0,0, 32'h80);
      tbl[6]  = mk(3'b010, 0,0, 7,32'h77, 0,0, 1,7,0, 3'b010, 1,7,32'h77, 32'h80);
      tbl[7]  = mk(3'b010, 0,0, 7,32'h78, 0,0, 0,0,0, 3'b010, 1,7,32'h78, 32'h0);
      tbl[8]  = mk(3'b001, 0,32'h55, 0,0, 0,0, 0,0,0, 3'b001, 0,0,0, 32'h0);
      tbl[9]  = mk(3'b000, 0,0, 0,0, 0,0, 1,0,0, 3'b000, 0,0,0, 32'h0);
      tbl[10] = mk(3'b000, 0,0, 0,0, 0,0, 1,4,0,  3'b000, 0,0,0, 32'h0010);
      tbl[11] = mk(3'b000, 0,0, 0,0, 0,0, 1,5,0,  3'b000, 0,0,0, 32'h0030);
      tbl[12] = mk(3'b000, 0,0, 0,0, 0,0, 1,6,0,  3'b000, 0,0,0, 32'h0070);
      tbl[13] = mk(3'b000, 0,0, 0,0, 0,0, 1,7,0,  3'b000, 0,0,0, 32'h00F0);
      tbl[14] = mk(3'b000, 0,0, 0,0, 0,0, 1,12,0, 3'b000, 0,0,0, 32'h10F0);
      tbl[15] = mk(3'b000, 0,0, 0,0, 0,0, 1,13,0, 3'b000, 0,0,0, 32'h30F0);
      tbl[16] = mk(3'b000, 0,0, 0,0, 0,0, 1,14,0, 3'b000, 0,0,0, 32'h70F0);
      tbl[17] = mk(3'b000, 0,0, 0,0, 0,0, 1,15,0, 3'b000, 0,0,0, 32'hF0F0);
      tbl[18] = mk(3'b000, 0,0, 0,0, 0,0, 1,3,1,  3'b000, 0,0,0, 32'h0);
      // Flush does not block a grant in the same cycle.
      tbl[19] = mk(3'b001, 9,32'h99, 0,0, 0,0, 1,9,1, 3'b001, 1,9,32'h99, 32'h0);
      tbl[20] = mk(3'b000, 0,0, 0,0, 0,0, 1,31,0, 3'b000, 0,0,0, 32'h80000000);
      tbl[21] = mk(3'b100, 0,0, 0,0, 31,32'hCAFE, 0,0,0, 3'b100, 1,31,32'hCAFE, 32'h0);

      clear_inputs();
      drive();
      model_reset();
      #22;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset state.
      chk("reset_wr_en",   {31'd0, bus.wr_en}, 32'd0);
      chk("reset_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
      chk("reset_wr_data", bus.wr_data, 32'd0);
      chk("reset_busy",    bus.busy, 32'd0);

      foreach (tbl[i]) begin
         cur_v[0] = tbl[i].v[0]; cur_a[0] = tbl[i].la; cur_d[0] = tbl[i].ld;
         cur_v[1] = tbl[i].v[1]; cur_a[1] = tbl[i].aa; cur_d[1] = tbl[i].ad;
         cur_v[2] = tbl[i].v[2]; cur_a[2] = tbl[i].ma; cur_d[2] = tbl[i].md;
         cur_ie = tbl[i].ie; cur_ia = tbl[i].ia; cur_fl = tbl[i].fl;
         step(r);
         chk($sformatf("tbl%0d_ready", i), {29'd0, r}, {29'd0, tbl[i].er});
         chk($sformatf("tbl%0d_wr_en", i), {31'd0, bus.wr_en}, {31'd0, tbl[i].ew});
         if (tbl[i].ew) begin
            chk($sformatf("tbl%0d_wr_addr", i), {27'd0, bus.wr_addr}, {27'd0, tbl[i].ea});
            chk($sformatf("tbl%0d_wr_data", i), bus.wr_data, tbl[i].ed);
         end
         chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].eb);
      end

      // Starvation: LSU requests every cycle, MDU waits; MDU wins on cycle 5,
      // then its counter restarts so it loses again on the following request.
      clear_inputs();
      cur_v[2] = 1'b1; cur_a[2] = 5'd10; cur_d[2] = 32'hA0;
      for (int c = 1; c <= 7; c++) begin
         cur_v[0] = 1'b1; cur_a[0] = 5'd9; cur_d[0] = 32'(c);
         step(r);
         chk($sformatf("starve_c%0d_mdu_ready", c), {31'd0, r[2]}, {31'd0, (c == 5)});
         chk($sformatf("starve_c%0d_lsu_ready", c), {31'd0, r[0]}, {31'd0, (c != 5)});
         if (r[2]) cur_v[2] = 1'b0;
         if (c == 5) begin
            chk("starve_mdu_wr_addr", {27'd0, bus.wr_addr}, 32'd10);
            cur_v[2] = 1'b1; cur_d[2] = 32'hA1;
         end
      end

      // Mid-run reset with LSU requesting and a busy bit pending.
      clear_inputs();
      cur_v[0] = 1'b1; cur_a[0] = 5'd4; cur_d[0] = 32'h44; cur_ie = 1'b1; cur_ia = 5'd8;
      step(r);
      chk("prerst_wr_en", {31'd0, bus.wr_en}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_wr_en", {31'd0, bus.wr_en}, 32'd0);
      chk("midrst_busy",  bus.busy, 32'd0);
      chk("midrst_ready", {29'd0, dut_rdy()}, 32'd0);
      @(posedge clk);
      #1;
      chk("midrst_ready_held", {29'd0, dut_rdy()}, 32'd0);
      chk("midrst_wr_en_held", {31'd0, bus.wr_en}, 32'd0);
      rst = 1'b0;
      model_reset();
      cur_ie = 1'b0;
      step(r);
      chk("postrst_lsu_ready", {29'd0, r}, 32'd1);
      chk("postrst_wr_addr", {27'd0, bus.wr_addr}, 32'd4);

      // Randomized traffic; sources hold their request until accepted.
      clear_inputs();
      for (int n = 0; n < 600; n++) begin
         for (int p = 0; p < 3; p++) begin
            if (!cur_v[p] && ($urandom_range(0, 2) != 0)) begin
               cur_v[p] = 1'b1;
               cur_a[p] = 5'($urandom_range(0, 31));
               cur_d[p] = $urandom;
            end
         end
         cur_ie = ($urandom_range(0, 2) == 0);
         cur_ia = 5'($urandom_range(0, 31));
         cur_fl = ($urandom_range(0, 19) == 0);
         step(r);
         for (int p = 0; p < 3; p++) if (r[p]) cur_v[p] = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
